// File: rtl/fp_fma_pkg.sv
// Shared constants, state encoding and record layout for the FMA operand gather.
// Optional row sequence checking is enabled with the ROW_CHECK_EN macro.
package fp_fma_pkg;

    localparam int DW       = 64;
    localparam int TAG_W    = 6;
    localparam int ROWS     = 14;
    localparam int DEPTH    = 2;
    localparam int ROW_W    = 4;
    localparam int WORD_W   = 70;
    localparam int SOF_BIT  = 69;
    localparam int MODE_LSB = 64;
    localparam int MODE_W   = 2;
    localparam int REC_W    = 3 * DW + MODE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GET_B = 2'd1,
        ST_GET_C = 2'd2,
        ST_GET_A = 2'd3
    } gather_st_e;

    typedef struct packed {
        logic [DW-1:0]     a;
        logic [DW-1:0]     b;
        logic [DW-1:0]     c;
        logic [MODE_W-1:0] mode;
    } triple_t;

    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
        return (r == ROW_W'(ROWS - 1)) ? '0 : r + 1'b1;
    endfunction

endpackage

// File: rtl/triple_fifo.sv
// Small synchronous FIFO holding completed operand triples.
// Push while full is accepted only when a pop happens in the same cycle.
module triple_fifo
    import fp_fma_pkg::*;
#(
    parameter int W     = REC_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_q];

    // Storage, pointers and occupancy; memory cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fma_operand_gather.sv
// Groups deserializer words into FMA operand triples and queues them for the datapath.
// Define ROW_CHECK_EN to add row sequence checking and the seq_err flag.
module fma_operand_gather
    import fp_fma_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ROW_W-1:0]  row,
    input  logic [WORD_W-1:0] din_word,
    output logic [DW-1:0]     op_a,
    output logic [DW-1:0]     op_b,
    output logic [DW-1:0]     op_c,
    output logic [MODE_W-1:0] rnd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
`ifdef ROW_CHECK_EN
    output logic              seq_err,
`endif
    output logic              busy
);

    gather_st_e        state_q, state_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              ovf_q;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              row_bad;
    logic              seq_set;
    logic              sof;
    logic [MODE_W-1:0] mode_in;
    logic [DW-1:0]     opnd;
    triple_t           rec_in;
    triple_t           rec_out;
    logic              unused_bits;

    assign sof     = din_word[SOF_BIT];
    assign mode_in = din_word[MODE_LSB +: MODE_W];
    assign opnd    = din_word[DW-1:0];

`ifdef ROW_CHECK_EN
    logic [ROW_W-1:0] exp_row_q;
    logic             seq_q;

    assign row_bad     = load && !sof && (state_q != ST_IDLE) && (row != exp_row_q);
    assign seq_err     = seq_q;
    assign unused_bits = ^din_word[68:66];

    // Expected row follows every accepted word; SOF resyncs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_row_q <= '0;
            seq_q     <= 1'b0;
        end else begin
            if (load && (sof || (state_q != ST_IDLE && !row_bad))) begin
                exp_row_q <= next_row(row);
            end
            if (seq_set) begin
                seq_q <= 1'b1;
            end
        end
    end
`else
    assign row_bad     = 1'b0;
    assign unused_bits = ^{din_word[68:66], row};
`endif

    // Next-state, staging and push decision for each incoming word.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        push    = 1'b0;
        seq_set = 1'b0;
        if (load) begin
            if (sof) begin
                a_d     = opnd;
                mode_d  = mode_in;
                state_d = ST_GET_B;
            end else if (row_bad) begin
                seq_set = 1'b1;
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_GET_A: begin
                        a_d     = opnd;
                        state_d = ST_GET_B;
                    end
                    ST_GET_B: begin
                        b_d     = opnd;
                        state_d = ST_GET_C;
                    end
                    ST_GET_C: begin
                        push    = 1'b1;
                        state_d = ST_GET_A;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // State, staging registers, mode latch and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign rec_in = '{a: a_q, b: b_q, c: opnd, mode: mode_q};
    assign pop    = out_valid && out_ready;

    triple_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign op_a      = rec_out.a;
    assign op_b      = rec_out.b;
    assign op_c      = rec_out.c;
    assign rnd_mode  = rec_out.mode;
    assign overflow  = ovf_q;
    assign busy      = (state_q == ST_GET_B) || (state_q == ST_GET_C) || !empty;

endmodule

// File: tb/tb_fma_operand_gather.sv
// Directed and randomized bench for fma_operand_gather against a word-list reference model.
// Build with ROW_CHECK_EN defined to exercise the row sequence checker.
module tb_fma_operand_gather;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [3:0]  row;
    logic [69:0] din_word;
    logic [63:0] op_a, op_b, op_c;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        busy;
`ifdef ROW_CHECK_EN
    logic        seq_err;
`endif

    always #5 clk = ~clk;

    fma_operand_gather dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .row       (row),
        .din_word  (din_word),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
`ifdef ROW_CHECK_EN
        .seq_err   (seq_err),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [1:0]  m;
    } trip_t;

    trip_t       mq[$];
    logic [63:0] part[$];
    bit          in_frame;
    logic [1:0]  m_mode;
    bit          m_ovf;
    bit          m_seq;
    int          m_exp;
    int          checks   = 0;
    int          failures = 0;
    int          rowc     = 0;

    function automatic logic [69:0] mk(bit s, logic [1:0] m, logic [63:0] op);
        return {s, 3'b000, m, op};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        part.delete();
        in_frame = 0;
        m_mode   = 2'b00;
        m_ovf    = 0;
        m_seq    = 0;
        m_exp    = 0;
    endtask

    task automatic model_cycle(bit ld, int rw, logic [69:0] w, bit rdy);
        bit    pop_now;
        bit    have;
        trip_t t;
        pop_now = rdy && (mq.size() > 0);
        have    = 0;
        if (ld) begin
            if (w[69]) begin
                part.delete();
                part.push_back(w[63:0]);
                m_mode   = w[65:64];
                in_frame = 1;
                m_exp    = (rw + 1) % 14;
            end else if (in_frame) begin
`ifdef ROW_CHECK_EN
                if (rw != m_exp) begin
                    in_frame = 0;
                    part.delete();
                    m_seq = 1;
                end else begin
`else
                begin
`endif
                    m_exp = (rw + 1) % 14;
                    part.push_back(w[63:0]);
                    if (part.size() == 3) begin
                        t    = '{part[0], part[1], part[2], m_mode};
                        have = 1;
                        part.delete();
                    end
                end
            end
        end
        if (pop_now) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < 2) mq.push_back(t);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("busy", 64'(busy), 64'((mq.size() > 0) || (part.size() > 0)));
        chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef ROW_CHECK_EN
        chk("seq_err", 64'(seq_err), 64'(m_seq));
`endif
        if (mq.size() > 0) begin
            chk("op_a", op_a, mq[0].a);
            chk("op_b", op_b, mq[0].b);
            chk("op_c", op_c, mq[0].c);
            chk("rnd_mode", 64'(rnd_mode), 64'(mq[0].m));
        end
    endtask

    task automatic step(bit ld, int rw, logic [69:0] w, bit rdy);
        load      = ld;
        row       = 4'(rw);
        din_word  = w;
        out_ready = rdy;
        @(posedge clk);
        model_cycle(ld, rw, w, rdy);
        #1;
        load = 1'b0;
        check_all();
    endtask

    task automatic wstep(logic [69:0] w, bit rdy);
        step(1'b1, rowc, w, rdy);
        rowc = (rowc + 1) % 14;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b1;
        din_word = mk(1'b1, 2'b11, 64'hDEAD);
        @(posedge clk);
        model_reset();
        #1;
        rst  = 1'b0;
        load = 1'b0;
        rowc = 0;
        check_all();
    endtask

    initial begin
        rst       = 1'b0;
        load      = 1'b0;
        row       = '0;
        din_word  = '0;
        out_ready = 1'b0;
        model_reset();

        do_reset();
        chk("rst_op_a", op_a, 64'h0);
        chk("rst_op_c", op_c, 64'h0);
        chk("rst_mode", 64'(rnd_mode), 64'h0);

        // Test 1: basic frame
        wstep(70'h204016000000000000, 1'b0);
        wstep(70'h004023000000000000, 1'b0);
        chk("t1_pre_valid", 64'(out_valid), 64'h0);
        wstep(70'h0040234CCCC0000000, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_a", op_a, 64'h4016000000000000);
        chk("t1_b", op_b, 64'h4023000000000000);
        chk("t1_c", op_c, 64'h40234CCCC0000000);
        chk("t1_mode", 64'(rnd_mode), 64'h0);
        step(1'b0, 0, '0, 1'b0);
        chk("t1_hold_a", op_a, 64'h4016000000000000);
        step(1'b0, 0, '0, 1'b1);
        chk("t1_drain", 64'(out_valid), 64'h0);

        // Test 2: overflow with stalled consumer
        do_reset();
        wstep(mk(1'b1, 2'b01, 64'h1), 1'b0);
        for (int i = 2; i <= 9; i++) wstep(mk(1'b0, 2'b11, 64'(i)), 1'b0);
        chk("t2_ovf", 64'(overflow), 64'h1);
        chk("t2_head_a", op_a, 64'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 1'b1);
        chk("t2_empty", 64'(out_valid), 64'h0);

        // Test 3: SOF restarts a partial triple
        do_reset();
        wstep(mk(1'b1, 2'b01, 64'hA1), 1'b1);
        wstep(mk(1'b0, 2'b00, 64'hB1), 1'b1);
        wstep(mk(1'b1, 2'b10, 64'hA2), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'hB2), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'hC2), 1'b0);
        chk("t3_a", op_a, 64'hA2);
        chk("t3_mode", 64'(rnd_mode), 64'h2);

        // Test 4: non-SOF words after reset are ignored
        do_reset();
        wstep(70'h003FD06C4C5974E65C, 1'b1);
        wstep(70'h003FD06C4C5974E65C, 1'b1);
        chk("t4_busy", 64'(busy), 64'h0);
        chk("t4_valid", 64'(out_valid), 64'h0);

        // Test 5: reset with queued triple and partial A,B
        do_reset();
        wstep(mk(1'b1, 2'b01, 64'h11), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'h12), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'h13), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'h14), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'h15), 1'b0);
        chk("t5_busy_pre", 64'(busy), 64'h1);
        do_reset();
        chk("t5_valid", 64'(out_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        wstep(mk(1'b1, 2'b11, 64'h21), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'h22), 1'b0);
        wstep(mk(1'b0, 2'b00, 64'h23), 1'b0);
        chk("t5_a", op_a, 64'h21);
        chk("t5_mode", 64'(rnd_mode), 64'h3);

        // Test 6: rows 0,1,3
        do_reset();
        step(1'b1, 0, mk(1'b1, 2'b00, 64'h31), 1'b1);
        step(1'b1, 1, mk(1'b0, 2'b00, 64'h32), 1'b1);
        step(1'b1, 3, mk(1'b0, 2'b00, 64'h33), 1'b1);
`ifdef ROW_CHECK_EN
        chk("t6_seq_err", 64'(seq_err), 64'h1);
        chk("t6_no_trip", 64'(out_valid), 64'h0);
`else
        chk("t6_trip", 64'(out_valid), 64'h1);
        chk("t6_c", op_c, 64'h33);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit          ld;
            bit          s;
            bit          rdy;
            int          rw;
            logic [69:0] w;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            ld  = ($urandom_range(0, 2) != 0);
            s   = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            w   = {s, 3'($urandom), 2'($urandom), $urandom, $urandom};
            rw  = rowc;
            if ($urandom_range(0, 15) == 0) rw = $urandom_range(0, 13);
            step(ld, rw, w, rdy);
            if (ld) rowc = (rw + 1) % 14;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
